bell_round_ctrl: RTL and testbench
==================================

Name: bell_round_ctrl

Overview:
Round sequencer and bell arbiter for the two-player bell game. It drives the card counter's deal enable and opens a press window. It arbitrates which player hit the bell first, samples the is_right verdict, and hands a single who/right result to score_control. It then waits for score_control's finish before dealing the next card, and flags game over after the configured number of rounds.

Parameters:
ROUNDS, 56, rounds (cards) per game before game over
ROUND_W, 6, width of round counter; must satisfy 2^ROUND_W > ROUNDS
PRESS_TIMEOUT, 50000, cycles the press window stays open after a deal
TMR_W, 16, width of press-window timer; must hold PRESS_TIMEOUT-1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  level; begins a game from IDLE or OVER
key1  input  1  player 1 bell key, debounced level
key2  input  1  player 2 bell key, debounced level
right  input  1  is_right verdict, valid in JUDGE cycle
score_done  input  1  score_control finish pulse
deal_en  output  1  one-cycle pulse to card counter enable
who  output  2  winner: 2'b01 player1, 2'b10 player2, 2'b00 none
right_q  output  1  latched verdict, stable while score_req=1
score_req  output  1  held high until score_done
press_open  output  1  high while press window open
round_cnt  output  ROUND_W  rounds dealt this game
game_over  output  1  high in OVER state

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, timer 0, key edge registers 0, tie-priority flag=player1.
- States: IDLE, DEAL, WAIT, JUDGE, SCORE, OVER.
- IDLE: if start=1, go to DEAL; round_cnt cleared.
- DEAL: deal_en=1 for exactly this cycle; round_cnt+1; timer loaded with PRESS_TIMEOUT-1; who/right_q cleared. Next state is WAIT.
- WAIT: press_open=1.
  - A press is a rising edge on key1/key2, detected against a registered previous value. Edge registers track the keys in every state, so a key held across the deal never counts.
  - First cycle with any edge latches who and goes to JUDGE.
  - Both edges in the same cycle resolve to player1 (fixed priority).
  - Timer at 0 with no edge: who=2'b00, right_q=0, go to SCORE.
  - Otherwise the timer decrements by 1.
- JUDGE: one cycle; right_q <= right; next state is SCORE. Key edges are ignored (lockout).
- SCORE: score_req=1; who and right_q held stable.
  - On score_done=1, score_req drops the next cycle.
  - If round_cnt==ROUNDS, go to OVER; else go to DEAL.
  - score_done seen in any other state is ignored.
- OVER: game_over=1; all other strobes 0. start=1 clears round_cnt and goes to DEAL.
- Latency: deal to first possible press sampled = 1 cycle. Press edge to score_req = 2 cycles (WAIT to JUDGE to SCORE).
- Reset asserted mid-round aborts immediately. No score_req is left pending.
- start in DEAL/WAIT/JUDGE/SCORE is ignored.

Optional Feature:
BELL_TIE_ALT_EN
- Defined: simultaneous presses alternate priority. The first tie after reset goes to player1; each resolved tie toggles the flag.
- Undefined: player1 always wins ties; the flag register is not built.

Decomposition:
- Shared package (bell_pkg): state encoding constants; WHO_NONE=2'b00, WHO_P1=2'b01, WHO_P2=2'b10.
- Natural sub-module: bell_press_arb. It contains the two edge detectors, the tie rule (including BELL_TIE_ALT_EN) and the grant output.
- FSM, timer and round counter stay in bell_round_ctrl.

Test Plan:
- Reset, start=1 one cycle: deal_en pulses once, round_cnt=1, press_open=1 from the next cycle.
- key2 rises 10 cycles after deal with right=1: 2 cycles later score_req=1, who=2'b10, right_q=1. score_done pulse, then next deal_en and round_cnt=2.
- key1 and key2 rise in the same cycle, twice:
  - Macro off: who=2'b01 both times.
  - BELL_TIE_ALT_EN on: who=2'b01 then 2'b10.
- key1 held high through DEAL, no new edges, PRESS_TIMEOUT=8: after 8 WAIT cycles, score_req=1 with who=2'b00 and right_q=0.
- ROUNDS=3 with quick presses: after the third score_done, game_over=1 and there is no deal_en. start=1 then gives round_cnt=1 and a fresh deal.
- rst=0 pulsed while score_req=1: all outputs 0 asynchronously, state IDLE. Keys and score_done are ignored until start.

Source files
------------

// File: rtl/bell_pkg.sv
// Shared constants for the bell game round controller and press arbiter.
// State encodings are plain localparams to stay compatible with existing
// code that compares against these values.
package bell_pkg;

    typedef logic [1:0] who_t;

    localparam who_t WHO_NONE = 2'b00;
    localparam who_t WHO_P1   = 2'b01;
    localparam who_t WHO_P2   = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DEAL  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_JUDGE = 3'd3;
    localparam logic [2:0] ST_SCORE = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

endpackage

// File: rtl/bell_press_arb.sv
// Bell press arbiter: rising-edge detection on both player keys and
// first-press / tie resolution into a single grant.
// Optional macro BELL_TIE_ALT_EN: simultaneous presses alternate priority
// (first tie after reset to player 1); otherwise player 1 always wins ties.
import bell_pkg::*;

module bell_press_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1,
    input  logic       key2,
    input  logic       arb_en,
    output logic [1:0] grant
);

    logic key1_q;
    logic key2_q;
    logic edge1;
    logic edge2;

    assign edge1 = key1 & ~key1_q;
    assign edge2 = key2 & ~key2_q;

    // Track key levels in every state so a key held across a deal never counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key1_q <= 1'b0;
            key2_q <= 1'b0;
        end else begin
            key1_q <= key1;
            key2_q <= key2;
        end
    end

`ifdef BELL_TIE_ALT_EN
    logic tie_p2;

    // Flip tie priority after each tie that is actually resolved in the window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tie_p2 <= 1'b0;
        end else if (arb_en && edge1 && edge2) begin
            tie_p2 <= ~tie_p2;
        end
    end
`endif

    // Resolve edges to a grant; nothing is granted outside the press window
    always_comb begin
        grant = WHO_NONE;
        if (arb_en) begin
            if (edge1 && edge2) begin
`ifdef BELL_TIE_ALT_EN
                grant = tie_p2 ? WHO_P2 : WHO_P1;
`else
                grant = WHO_P1;
`endif
            end else if (edge1) begin
                grant = WHO_P1;
            end else if (edge2) begin
                grant = WHO_P2;
            end
        end
    end

endmodule

// File: rtl/bell_round_ctrl.sv
// Round sequencer for the two-player bell game: deals cards, opens the press
// window, latches winner and verdict for score_control, counts rounds.
// Tie behaviour depends on BELL_TIE_ALT_EN inside bell_press_arb.
import bell_pkg::*;

module bell_round_ctrl #(
    parameter int ROUNDS        = 56,
    parameter int ROUND_W       = 6,
    parameter int PRESS_TIMEOUT = 50000,
    parameter int TMR_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               key1,
    input  logic               key2,
    input  logic               right,
    input  logic               score_done,
    output logic               deal_en,
    output logic [1:0]         who,
    output logic               right_q,
    output logic               score_req,
    output logic               press_open,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               game_over
);

    localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(PRESS_TIMEOUT - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS);

    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic [1:0]       grant;

    // Strobes decode straight from state, so an async reset clears them at once
    assign deal_en    = (state == ST_DEAL);
    assign press_open = (state == ST_WAIT);
    assign score_req  = (state == ST_SCORE);
    assign game_over  = (state == ST_OVER);

    bell_press_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .key1   (key1),
        .key2   (key2),
        .arb_en (press_open),
        .grant  (grant)
    );

    // Round FSM, press-window timer, round counter and result latches.
    // The round count and result clear are applied on entry to DEAL so that
    // round_cnt already shows the new round while deal_en is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            timer     <= '0;
            round_cnt <= '0;
            who       <= WHO_NONE;
            right_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state     <= ST_DEAL;
                        round_cnt <= ROUND_W'(1);
                        who       <= WHO_NONE;
                        right_q   <= 1'b0;
                    end
                end
                ST_DEAL: begin
                    timer <= TMR_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (grant != WHO_NONE) begin
                        who   <= grant;
                        state <= ST_JUDGE;
                    end else if (timer == '0) begin
                        who     <= WHO_NONE;
                        right_q <= 1'b0;
                        state   <= ST_SCORE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_JUDGE: begin
                    right_q <= right;
                    state   <= ST_SCORE;
                end
                ST_SCORE: begin
                    if (score_done) begin
                        if (round_cnt == ROUND_LAST) begin
                            state <= ST_OVER;
                        end else begin
                            state     <= ST_DEAL;
                            round_cnt <= round_cnt + ROUND_W'(1);
                            who       <= WHO_NONE;
                            right_q   <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bell_round_ctrl.sv
// Scoreboard bench for bell_round_ctrl (ROUNDS=3, PRESS_TIMEOUT=12).
// Expected tie winners follow BELL_TIE_ALT_EN when it is defined.
module tb_bell_round_ctrl;

    localparam int RW = 6;

    typedef struct {
        logic [1:0]    who;
        logic          rq;
        logic [RW-1:0] rnd;
    } score_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          key1;
    logic          key2;
    logic          right;
    logic          score_done;
    logic          deal_en;
    logic [1:0]    who;
    logic          right_q;
    logic          score_req;
    logic          press_open;
    logic [RW-1:0] round_cnt;
    logic          game_over;

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0] deal_q[$];
    score_t        score_q[$];

    bell_round_ctrl #(
        .ROUNDS        (3),
        .ROUND_W       (RW),
        .PRESS_TIMEOUT (12),
        .TMR_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key1       (key1),
        .key2       (key2),
        .right      (right),
        .score_done (score_done),
        .deal_en    (deal_en),
        .who        (who),
        .right_q    (right_q),
        .score_req  (score_req),
        .press_open (press_open),
        .round_cnt  (round_cnt),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations on each deal strobe and each new score request
    score_t cur;
    logic   req_seen = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (deal_en) begin
                if (deal_q.size() == 0) begin
                    check("deal_unexpected", 32'd1, 32'd0);
                end else begin
                    check("deal_round", 32'(round_cnt), 32'(deal_q.pop_front()));
                    check("deal_window_closed", 32'(press_open), 32'd0);
                end
            end
            if (score_req && !req_seen) begin
                req_seen = 1'b1;
                if (score_q.size() == 0) begin
                    check("score_unexpected", 32'd1, 32'd0);
                    cur = '{who: 2'b11, rq: 1'bx, rnd: '0};
                end else begin
                    cur = score_q.pop_front();
                    check("score_who",   32'(who),       32'(cur.who));
                    check("score_right", 32'(right_q),   32'(cur.rq));
                    check("score_round", 32'(round_cnt), 32'(cur.rnd));
                end
            end else if (score_req) begin
                check("score_hold", {30'd0, who}, {30'd0, cur.who});
                check("score_hold_right", 32'(right_q), 32'(cur.rq));
            end
            if (!score_req) req_seen = 1'b0;
        end else begin
            req_seen = 1'b0;
        end
    end

    task automatic wait_deal();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!deal_en && n < 50);
        if (!deal_en) check("deal_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_score(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!score_req && n < 50);
        if (!score_req) check("score_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_score(input logic last, input logic [RW-1:0] rnd);
        @(posedge clk); #1;
        key1 = 1'b0;
        key2 = 1'b0;
        right = 1'b0;
        if (!last) deal_q.push_back(rnd + RW'(1));
        score_done = 1'b1;
        @(posedge clk); #1;
        score_done = 1'b0;
    endtask

    task automatic do_press(input logic k1, input logic k2, input logic rv,
                            input logic [1:0] exp_who, input logic exp_r,
                            input logic [RW-1:0] rnd, input int dly, input logic last);
        int n;
        wait_deal();
        score_q.push_back('{who: exp_who, rq: exp_r, rnd: rnd});
        repeat (dly) @(posedge clk);
        #1;
        key1 = k1;
        key2 = k2;
        right = rv;
        wait_score(n);
        check("press_latency", 32'(n), 32'd3);
        finish_score(last, rnd);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; key1 = 1'b0; key2 = 1'b0;
        right = 1'b0; score_done = 1'b0;
        #2;
        check("reset_outputs",
              {20'd0, deal_en, who, right_q, score_req, press_open, round_cnt, game_over},
              32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Game 1: single press by player 2, then two ties, then game over
        deal_q.push_back(RW'(1));
        pulse_start();
        do_press(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, RW'(1), 10, 1'b0);
        do_press(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, RW'(2), 3, 1'b0);
`ifdef BELL_TIE_ALT_EN
        do_press(1'b1, 1'b1, 1'b1, 2'b10, 1'b1, RW'(3), 2, 1'b1);
`else
        do_press(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, RW'(3), 2, 1'b1);
`endif
        repeat (4) @(negedge clk);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_round", 32'(round_cnt), 32'd3);
        check("over_strobes", {30'd0, score_req, press_open}, 32'd0);

        // Game 2 round 1: key1 held across the deal never counts, window times out
        @(posedge clk); #1;
        key1 = 1'b1;
        right = 1'b1;
        deal_q.push_back(RW'(1));
        pulse_start();
        wait_deal();
        score_q.push_back('{who: 2'b00, rq: 1'b0, rnd: RW'(1)});
        n = 0;
        do begin
            @(negedge clk);
            if (press_open) n++;
        end while (!score_req && n < 100);
        check("timeout_window_len", 32'(n), 32'd12);
        finish_score(1'b0, RW'(1));

        // Game 2 round 2: key2 rising during JUDGE is locked out
        wait_deal();
        score_q.push_back('{who: 2'b01, rq: 1'b1, rnd: RW'(2)});
        repeat (2) @(posedge clk);
        #1;
        key1 = 1'b1;
        right = 1'b1;
        @(posedge clk); #1;
        key2 = 1'b1;
        wait_score(n);
        check("lockout_latency", 32'(n), 32'd2);
        @(negedge clk);

        // Asynchronous reset while score_req is pending
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("async_reset_outputs",
              {20'd0, deal_en, who, right_q, score_req, press_open, round_cnt, game_over},
              32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        key1 = 1'b0;
        key2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            key1 = i[0];
            key2 = i[1];
            score_done = i[0];
            @(negedge clk);
            check("idle_ignores_inputs",
                  {23'd0, deal_en, score_req, press_open, game_over, round_cnt[4:0]}, 32'd0);
        end
        @(posedge clk); #1;
        key1 = 1'b0;
        key2 = 1'b0;
        score_done = 1'b0;

        deal_q.push_back(RW'(1));
        pulse_start();
        wait_deal();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(deal_q.size() + score_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
